// File: rtl/phase_sequencer_if.sv
// Board-side bundle for phase_sequencer: keypad strobe, per-puzzle pulse and
// display buses in, puzzle enables and muxed board outputs back out.
// master = the side driving keypad and puzzle signals, slave = the sequencer.
interface phase_sequencer_if #(
  parameter int NUM_PUZZLES = 4
);
  logic                        key_valid;
  logic [3:0]                  key_value;
  logic [NUM_PUZZLES-1:0]      pz_clear;
  logic [NUM_PUZZLES-1:0]      pz_fail;
  logic [NUM_PUZZLES-1:0]      pz_correct;
  logic [32*NUM_PUZZLES-1:0]   pz_seg_data;
  logic [8*NUM_PUZZLES-1:0]    pz_led;
  logic [NUM_PUZZLES-1:0]      pz_enable;
  logic                        pz_key_valid;
  logic [31:0]                 seg_data;
  logic [7:0]                  led_out;
  logic [7:0]                  stability;
  logic [2:0]                  stage_idx;
  logic                        phase_win;
  logic                        phase_lose;

  modport master (
    output key_valid, key_value, pz_clear, pz_fail, pz_correct, pz_seg_data, pz_led,
    input  pz_enable, pz_key_valid, seg_data, led_out, stability, stage_idx,
           phase_win, phase_lose
  );

  modport slave (
    input  key_valid, key_value, pz_clear, pz_fail, pz_correct, pz_seg_data, pz_led,
    output pz_enable, pz_key_valid, seg_data, led_out, stability, stage_idx,
           phase_win, phase_lose
  );
endinterface

// File: rtl/phase_sequencer.sv
// phase_sequencer: walks one phase of puzzles, enabling one slot at a time,
// keeping a stability score from the active slot's correct/fail pulses and
// ending in WIN (all slots cleared) or LOSE (stability exhausted).
// Optional feature macro: STABILITY_DECAY_EN (stability bleeds 1 point every
// DECAY_PERIOD cycles spent in RUN).
module phase_sequencer #(
  parameter int NUM_PUZZLES   = 4,
  parameter int STAB_INIT     = 100,
  parameter int STAB_MAX      = 100,
  parameter int FAIL_PENALTY  = 10,
  parameter int CORRECT_BONUS = 5,
  parameter int SHOW_CYCLES   = 50_000_000,
  parameter int DECAY_PERIOD  = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  phase_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_CLEAR_SHOW,
    ST_FAIL_SHOW,
    ST_WIN,
    ST_LOSE
  } state_t;

  localparam int              CNT_W      = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [8:0]      INIT9      = 9'(STAB_INIT);
  localparam logic [8:0]      MAX9       = 9'(STAB_MAX);
  localparam logic [8:0]      BONUS9     = 9'(CORRECT_BONUS);
  localparam logic [8:0]      PEN9       = 9'(FAIL_PENALTY);
  localparam logic [2:0]      LAST_STAGE = 3'(NUM_PUZZLES - 1);
  localparam logic [3:0]      KEY_HASH   = 4'd11;

  // Elaboration-time guards on the parameter ranges the datapath assumes.
  if (NUM_PUZZLES < 2 || NUM_PUZZLES > 8) begin : g_bad_num
    $error("phase_sequencer: NUM_PUZZLES must be 2..8");
  end
  if (SHOW_CYCLES < 1 || DECAY_PERIOD < 1) begin : g_bad_period
    $error("phase_sequencer: SHOW_CYCLES and DECAY_PERIOD must be >= 1");
  end
  if (STAB_MAX > 255 || STAB_INIT > STAB_MAX) begin : g_bad_stab
    $error("phase_sequencer: need STAB_INIT <= STAB_MAX <= 255");
  end

  state_t                 state_q, state_d;
  logic [7:0]             stab_q, stab_d;
  logic [2:0]             stage_q, stage_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_PUZZLES-1:0] en_q, en_d;
  logic                   win_q, win_d;
  logic                   lose_q, lose_d;

  logic                   key_hash;
  logic                   act_clear, act_fail, act_correct;
  logic [31:0]            act_seg;
  logic [7:0]             act_led;
  logic [8:0]             sum9;
  logic                   decay_tick;

  assign key_hash = bus.key_valid && (bus.key_value == KEY_HASH);

  // Select the active slot's pulses and display data; other slots are ignored.
  always_comb begin
    act_clear   = 1'b0;
    act_fail    = 1'b0;
    act_correct = 1'b0;
    act_seg     = 32'h0;
    act_led     = 8'h0;
    for (int k = 0; k < NUM_PUZZLES; k++) begin
      if (stage_q == 3'(k)) begin
        act_clear   = bus.pz_clear[k];
        act_fail    = bus.pz_fail[k];
        act_correct = bus.pz_correct[k];
        act_seg     = bus.pz_seg_data[32*k +: 32];
        act_led     = bus.pz_led[8*k +: 8];
      end
    end
  end

`ifdef STABILITY_DECAY_EN
  localparam int               DCY_W    = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [DCY_W-1:0] DCY_LAST = DCY_W'(DECAY_PERIOD - 1);

  logic [DCY_W-1:0] dcy_q, dcy_d;

  // Decay counter: held at 0 outside RUN so every entry to RUN starts fresh.
  always_comb begin
    dcy_d      = '0;
    decay_tick = 1'b0;
    if (state_q == ST_RUN) begin
      decay_tick = (dcy_q == DCY_LAST);
      dcy_d      = decay_tick ? '0 : dcy_q + 1'b1;
    end
  end

  // Decay counter register.
  always_ff @(posedge clk) begin
    if (rst) dcy_q <= '0;
    else     dcy_q <= dcy_d;
  end
`else
  assign decay_tick = 1'b0;
`endif

  // Next-state, stability update, show counter and registered-output decode.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    state_d = state_q;
    stab_d  = stab_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    sum9    = {1'b0, stab_q};

    unique case (state_q)
      ST_IDLE: begin
        if (key_hash) begin
          stab_d  = INIT9[7:0];
          stage_d = 3'd0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // Correct first, then fail; clear wins over fail and discards it.
        if (act_correct) begin
          sum9 = sum9 + BONUS9;
          if (sum9 > MAX9) sum9 = MAX9;
        end
        if (act_clear) begin
          state_d = ST_CLEAR_SHOW;
          cnt_d   = SHOW_LOAD;
        end else if (act_fail) begin
          sum9    = (sum9 >= PEN9) ? sum9 - PEN9 : 9'd0;
          state_d = (sum9 == 9'd0) ? ST_LOSE : ST_FAIL_SHOW;
          cnt_d   = SHOW_LOAD;
        end
        // Decay is applied after any pulse and can itself end the phase.
        if (decay_tick) begin
          if (sum9 != 9'd0) sum9 = sum9 - 9'd1;
          if (sum9 == 9'd0) state_d = ST_LOSE;
        end
        stab_d = sum9[7:0];
      end

      ST_CLEAR_SHOW: begin
        if (cnt_q == '0) begin
          if (stage_q == LAST_STAGE) begin
            state_d = ST_WIN;
          end else begin
            stage_d = stage_q + 3'd1;
            state_d = ST_RUN;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_FAIL_SHOW: begin
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end

      ST_WIN, ST_LOSE: begin
        if (key_hash) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Registered outputs are decoded from the next state so they line up
    // with the state register.
    for (int k = 0; k < NUM_PUZZLES; k++) begin
      en_d[k] = (state_d == ST_RUN) && (stage_d == 3'(k));
    end
    win_d  = (state_d == ST_WIN);
    lose_d = (state_d == ST_LOSE);
  end

  // State and registered outputs; rst discards any pulse seen this cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
      stab_q  <= INIT9[7:0];
      stage_q <= 3'd0;
      cnt_q   <= '0;
      en_q    <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
    end
  end

  // Board display mux: live puzzle data in RUN, fixed banners elsewhere.
  always_comb begin
    bus.seg_data = 32'hFFFF_FFFF;
    bus.led_out  = 8'h00;
    unique case (state_q)
      ST_IDLE:       begin bus.seg_data = 32'hFFFF_FFFF; bus.led_out = 8'h00; end
      ST_RUN:        begin bus.seg_data = act_seg;       bus.led_out = act_led; end
      ST_CLEAR_SHOW: begin bus.seg_data = 32'hCCCC_CCCC; bus.led_out = 8'hFF; end
      ST_FAIL_SHOW:  begin bus.seg_data = 32'hEEEE_EEEE; bus.led_out = 8'h00; end
      ST_WIN:        begin bus.seg_data = 32'h1111_1111; bus.led_out = 8'hFF; end
      ST_LOSE:       begin bus.seg_data = 32'h0000_0000; bus.led_out = 8'h00; end
      default:       begin bus.seg_data = 32'hFFFF_FFFF; bus.led_out = 8'h00; end
    endcase
  end

  assign bus.pz_key_valid = bus.key_valid && (state_q == ST_RUN);
  assign bus.pz_enable    = en_q;
  assign bus.stability    = stab_q;
  assign bus.stage_idx    = stage_q;
  assign bus.phase_win    = win_q;
  assign bus.phase_lose   = lose_q;

endmodule
